// File: rtl/matmul_seq_ctrl.sv
// Sequencer for a DIM x DIM matrix multiply on a single MAC: streams A and B into
// operand storage, walks every i/j/k product, and writes each result element out.
module matmul_seq_ctrl #(
    parameter int DIM    = 3,
    parameter int IDX_W  = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              skip_load,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_we,
    output logic              load_mat,
    output logic [ADDR_W-1:0] load_addr,
    output logic [IDX_W-1:0]  a_row,
    output logic [IDX_W-1:0]  b_col,
    output logic [IDX_W-1:0]  k_idx,
    output logic              mac_clr,
    output logic              mac_en,
    input  logic              out_ready,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done
);

    localparam int ELEMS = DIM * DIM;
    localparam int N_W   = $clog2(2 * ELEMS);

    localparam logic [N_W-1:0]   N_LAST   = N_W'(2 * ELEMS - 1);
    localparam logic [N_W-1:0]   N_HALF   = N_W'(ELEMS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [N_W-1:0]   n_q;
    logic [IDX_W-1:0] i_q, j_q, k_q;
    logic             load_acc;
    logic             last_elem;

    assign load_acc  = (state == S_LOAD) && in_valid;
    assign last_elem = (i_q == IDX_LAST) && (j_q == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (start) state_nx = skip_load ? S_COMPUTE : S_LOAD;
            S_LOAD:    if (load_acc && (n_q == N_LAST)) state_nx = S_COMPUTE;
            S_COMPUTE: if (k_q == IDX_LAST) state_nx = S_WRITE;
            S_WRITE:   if (out_ready) state_nx = last_elem ? S_DONE : S_COMPUTE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nx = S_IDLE;
    end

    // Counters hold outside their active state; n stops at its last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q <= '0;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && skip_load) begin
                        i_q <= '0;
                        j_q <= '0;
                        k_q <= '0;
                    end else if (start) begin
                        n_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_acc) begin
                        if (n_q == N_LAST) begin
                            i_q <= '0;
                            j_q <= '0;
                            k_q <= '0;
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: k_q <= (k_q == IDX_LAST) ? '0 : k_q + 1'b1;
                S_WRITE: begin
                    if (out_ready && !last_elem) begin
                        if (j_q == IDX_LAST) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_LOAD);
        load_we   = load_acc;
        load_mat  = (n_q >= N_HALF);
        load_addr = ADDR_W'(load_mat ? n_q - N_HALF : n_q);
        a_row     = i_q;
        b_col     = j_q;
        k_idx     = k_q;
        mac_en    = (state == S_COMPUTE);
        mac_clr   = (state == S_COMPUTE) && (k_q == '0);
        res_we    = (state == S_WRITE) && out_ready;
        res_addr  = ADDR_W'(int'(i_q) * DIM + int'(j_q));
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

- Parametrised sequencer for a DIM×DIM matrix-multiply datapath with a single MAC.
- Loads operand matrices A and B into operand storage through a valid/ready stream.
- Steps the MAC through every row/column/k product, then writes each result element to the output buffer, honouring back-pressure.
- Sits between the input register bank, the operand muxes/MAC, and the result memory. Replaces the fixed 12-step load sequencer with a generic, start/done-handshaked controller that can also reuse loaded operands.

## Interface

Parameters:
- DIM, 3, matrix dimension (square), ≥2
- IDX_W, 2, width of row/col/k indices; 2^IDX_W ≥ DIM
- ADDR_W, 4, width of element addresses; 2^ADDR_W ≥ DIM*DIM

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset; one clock domain
- start  in  1  begin a job; sampled only in IDLE
- skip_load  in  1  sampled with start; 1 = reuse stored A/B and go straight to compute
- abort  in  1  synchronous cancel; any non-IDLE state → IDLE next edge, no done
- in_valid  in  1  load stream element valid
- in_ready  out  1  controller accepts load element (high only in LOAD)
- load_we  out  1  = in_valid & in_ready; operand write strobe
- load_mat  out  1  0 = element targets A, 1 = targets B
- load_addr  out  ADDR_W  element index within target matrix, row-major
- a_row  out  IDX_W  A row select i
- b_col  out  IDX_W  B column select j
- k_idx  out  IDX_W  inner index k (A column / B row)
- mac_clr  out  1  MAC loads product instead of accumulating (first k)
- mac_en  out  1  MAC captures this cycle
- out_ready  in  1  result buffer can accept
- res_we  out  1  result write strobe
- res_addr  out  ADDR_W  result index i*DIM+j
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion

## Operation

States: IDLE, LOAD, COMPUTE, WRITE, DONE.
- IDLE:
  - start=1, skip_load=0 → LOAD, with load counter cleared.
  - start=1, skip_load=1 → COMPUTE, with i=j=k=0.
  - start=0 → stay.
- LOAD:
  - Load counter n runs 0..2*DIM*DIM-1 and advances only on load_we.
  - load_mat = (n ≥ DIM*DIM); load_addr = n mod DIM*DIM.
  - Accept of n = 2*DIM*DIM-1 → COMPUTE, with i=j=k=0.
  - in_valid low: hold state and counter; no write.
- COMPUTE:
  - mac_en=1 every cycle; mac_clr = (k==0).
  - Outputs a_row=i, b_col=j, k_idx=k.
  - k increments each cycle; at k==DIM-1, → WRITE and k←0.
- WRITE:
  - res_we = out_ready; res_addr = i*DIM+j; MAC holds, mac_en=0.
  - out_ready=0: stay, with res_addr held.
  - On accept, if i==j==DIM-1 → DONE. Otherwise advance j (wrapping to 0 and incrementing i) and → COMPUTE.
- DONE: done=1 for one cycle → IDLE.
- abort beats every other transition. start in a non-IDLE state is ignored.
- All index outputs are driven from registered counters. They hold their last value outside their active state, except load_addr/load_mat, which track counter n.
- Operand storage is not cleared by the controller. A skip_load job after reset computes on whatever the storage holds, and is legal.

## Timing

- Reset (reset=0): state IDLE, all counters 0. All outputs 0: in_ready, load_we, load_mat, load_addr, a_row, b_col, k_idx, mac_clr, mac_en, res_we, res_addr, busy, done.
- Reset asserted mid-job: immediate return to IDLE; no res_we or done follows.
- load_we and res_we are the only outputs combinational on inputs (in_valid, out_ready). All others are Moore.
- MAC latency of 1: the product issued in the last COMPUTE cycle is in the accumulator during the following WRITE cycle.
- Unstalled job latency (first busy cycle = cycle 1):
  - full load: 2*DIM² + DIM²*(DIM+1), with done in the next cycle.
  - DIM=3, full load: done in cycle 55.
  - DIM=3, skip_load: done in cycle 37.
- Each in_valid=0 cycle in LOAD adds one cycle. Each out_ready=0 cycle in WRITE adds one cycle.
- start=1 in the same cycle as done: ignored (state is DONE). A new job starts from IDLE on the next start.

## Test plan

- Reset then idle, DIM=3: all outputs 0, busy=0. Pulse start with in_valid=1 and out_ready=1 → 18 load_we with load_addr 0..8 (load_mat 0) then 0..8 (load_mat 1). Then 9 WRITEs with res_addr 0..8, done in cycle 55. A=[1..9], B=identity → result equals A.
- in_valid toggled every other cycle → exactly 18 writes, addresses gap-free, done delayed by 18 cycles.
- out_ready held low 5 cycles at res_addr=4 → res_we stays 0, res_addr stays 4, MAC unchanged; write completes on release.
- skip_load=1 after the first job → no in_ready, 9 results identical to the first job, done in cycle 37.
- abort during COMPUTE at i=1, j=1 → IDLE next cycle, busy=0, no done, no further res_we.
- reset=0 asserted mid-LOAD (n=7), then released, then start → load restarts at load_addr 0, load_mat 0.
